// File: rtl/display_pkg.sv
// Shared encodings for the board display: game status values (matching the game
// controller), seven-segment glyphs and the decoder's 5-bit symbol codes.
package display_pkg;

    localparam logic [1:0] CHOSE_BOARD  = 2'b00;
    localparam logic [1:0] GAMING       = 2'b01;
    localparam logic [1:0] GAME_INITIAL = 2'b10;
    localparam logic [1:0] WINNED       = 2'b11;

    // Symbol codes: 0x00-0x0F are hex digits; C and d reuse the hex codes.
    localparam logic [4:0] CODE_C     = 5'h0C;
    localparam logic [4:0] CODE_D     = 5'h0D;
    localparam logic [4:0] CODE_G     = 5'h10;
    localparam logic [4:0] CODE_I     = 5'h11;
    localparam logic [4:0] CODE_BLANK = 5'h12;

    // Segment order {dp,g,f,e,d,c,b,a}, active-high.
    localparam logic [7:0] GLYPH_G     = 8'h3D;
    localparam logic [7:0] GLYPH_I     = 8'h06;
    localparam logic [7:0] GLYPH_BLANK = 8'h00;

    // Element [n] is the glyph for hex digit n.
    localparam logic [15:0][7:0] HEX_GLYPHS = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    function automatic logic [4:0] status_code(input logic [1:0] status);
        case (status)
            CHOSE_BOARD:  return CODE_C;
            GAMING:       return CODE_G;
            GAME_INITIAL: return CODE_I;
            default:      return CODE_D;
        endcase
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational symbol-code to seven-segment decoder: 16 hex glyphs, the
// status letters G and I, and blank for every other code.
module seg_decoder
    import display_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [7:0] o_seg
);

    // NOTE: o_seg gets a default before any branch so no path can infer a latch.
    always_comb begin
        o_seg = GLYPH_BLANK;
        if (!i_code[4]) begin
            o_seg = HEX_GLYPHS[i_code[3:0]];
        end else begin
            case (i_code)
                CODE_G:  o_seg = GLYPH_G;
                CODE_I:  o_seg = GLYPH_I;
                default: o_seg = GLYPH_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/board_display_scan.sv
// 8-digit multiplexed seven-segment scanner for the game board, status and step
// count; inputs are snapshotted only at frame start, board digits blink on a win.
module board_display_scan
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk_d,
    input  logic        rst,
    input  logic [11:0] board,
    input  logic [1:0]  game_status,
    input  logic [5:0]  step_number,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [11:0]   r_board;
    logic [1:0]    r_status;
    logic [5:0]    r_step;
    logic [FW-1:0] r_cnt;
    logic          r_phase;

    logic          w_tick;
    logic          w_frame_start;
    logic [2:0]    w_idx_n;
    logic [11:0]   w_board_n;
    logic [1:0]    w_status_n;
    logic [5:0]    w_step_n;
    logic [FW-1:0] w_cnt_n;
    logic          w_phase_n;
    logic [3:0]    w_tens;
    logic [3:0]    w_ones;
    logic [4:0]    w_code;
    logic [7:0]    w_seg;

    assign w_tick        = (r_presc == PW'(SCAN_DIV - 1));
    assign w_idx_n       = r_idx + 3'd1;
    assign w_frame_start = w_tick && (r_idx == 3'd7);

    // Digit 0 is decoded in the frame-start cycle, so it must see the values
    // being latched rather than the previous frame's snapshot.
    assign w_board_n  = w_frame_start ? board       : r_board;
    assign w_status_n = w_frame_start ? game_status : r_status;
    assign w_step_n   = w_frame_start ? step_number : r_step;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_d) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= 3'd7;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= w_idx_n;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // A frame only counts toward blinking if WINNED held for the whole frame
    // just ended; leaving WINNED drops the blink state in the same frame start.
    always_comb begin
        w_cnt_n   = r_cnt;
        w_phase_n = r_phase;
        if (w_frame_start) begin
            if (w_status_n != WINNED) begin
                w_cnt_n   = '0;
                w_phase_n = 1'b0;
            end else if (r_status == WINNED) begin
                if (r_cnt == FW'(BLINK_FRAMES - 1)) begin
                    w_cnt_n   = '0;
                    w_phase_n = ~r_phase;
                end else begin
                    w_cnt_n = r_cnt + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            r_board  <= '0;
            r_status <= '0;
            r_step   <= '0;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else begin
            r_board  <= w_board_n;
            r_status <= w_status_n;
            r_step   <= w_step_n;
            r_cnt    <= w_cnt_n;
            r_phase  <= w_phase_n;
        end
    end

    assign w_tens = 4'(w_step_n / 6'd10);
    assign w_ones = 4'(w_step_n - 6'(w_tens) * 6'd10);

    always_comb begin
        w_code = CODE_BLANK;
        case (w_idx_n)
            3'd0:    w_code = {1'b0, w_board_n[3:0]};
            3'd1:    w_code = {1'b0, w_board_n[7:4]};
            3'd2:    w_code = {1'b0, w_board_n[11:8]};
            3'd4:    w_code = status_code(w_status_n);
            3'd6:    w_code = {1'b0, w_ones};
            3'd7:    w_code = (w_tens == 4'd0) ? CODE_BLANK : {1'b0, w_tens};
            default: w_code = CODE_BLANK;
        endcase
        if (w_phase_n && (w_idx_n <= 3'd2)) begin
            w_code = CODE_BLANK;
        end
    end

    seg_decoder u_seg_decoder (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    always_ff @(posedge clk_d) begin
        if (rst) begin
            an  <= 8'h00;
            seg <= 8'h00;
        end else if (w_tick) begin
            an  <= 8'h01 << w_idx_n;
            seg <= w_seg;
        end
    end

endmodule

// File: tb/tb_board_display_scan.sv
// Directed bench for board_display_scan with SCAN_DIV=4, BLINK_FRAMES=2: frame
// vectors from a table plus hand sequences for snapshot, blink and reset cases.
module tb_board_display_scan;
    import display_pkg::*;

    localparam int SD = 4;
    localparam int BF = 2;

    typedef logic [0:7][7:0] frame_t;
    typedef struct {
        logic [11:0] board;
        logic [1:0]  status;
        logic [5:0]  step;
        frame_t      segs;
    } vec_t;

    logic        clk_d = 1'b0;
    logic        rst;
    logic [11:0] board;
    logic [1:0]  game_status;
    logic [5:0]  step_number;
    logic [7:0]  an;
    logic [7:0]  seg;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[5];

    board_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk_d       (clk_d),
        .rst         (rst),
        .board       (board),
        .game_status (game_status),
        .step_number (step_number),
        .an          (an),
        .seg         (seg)
    );

    always #5 clk_d = ~clk_d;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic set_inputs(input logic [11:0] b, input logic [1:0] s, input logic [5:0] n);
        board       = b;
        game_status = s;
        step_number = n;
    endtask

    task automatic sample_slot(input int d, input logic [7:0] exp_seg, input string tag);
        logic [7:0] exp_an;
        exp_an = 8'h01 << d;
        check($sformatf("%s_an%0d", tag, d), an, exp_an);
        check($sformatf("%s_seg%0d", tag, d), seg, exp_seg);
    endtask

    task automatic run_slot(input int d, input logic [7:0] exp_seg, input string tag);
        repeat (SD) @(negedge clk_d);
        sample_slot(d, exp_seg, tag);
    endtask

    task automatic run_frame(input frame_t exp, input string tag);
        for (int d = 0; d < 8; d++) run_slot(d, exp[d], tag);
    endtask

    // Called on the negedge where rst was just released.
    task automatic run_after_reset(input frame_t exp, input string tag);
        for (int k = 0; k < SD - 1; k++) begin
            @(negedge clk_d);
            check($sformatf("%s_idle_an%0d", tag, k), an, 8'h00);
            check($sformatf("%s_idle_seg%0d", tag, k), seg, 8'h00);
        end
        @(negedge clk_d);
        sample_slot(0, exp[0], tag);
        for (int d = 1; d < 8; d++) run_slot(d, exp[d], tag);
    endtask

    function automatic frame_t win_frame(input logic blank);
        logic [7:0] b;
        b = blank ? 8'h00 : 8'h06;
        return {b, b, b, 8'h00, 8'h5E, 8'h00, 8'h6D, 8'h00};
    endfunction

    initial begin
        frame_t f;

        vecs[0] = '{12'hA3F, GAMING,       6'd0,
                    {8'h71, 8'h4F, 8'h77, 8'h00, 8'h3D, 8'h00, 8'h3F, 8'h00}};
        vecs[1] = '{12'h012, CHOSE_BOARD,  6'd9,
                    {8'h5B, 8'h06, 8'h3F, 8'h00, 8'h39, 8'h00, 8'h6F, 8'h00}};
        vecs[2] = '{12'h7D8, GAME_INITIAL, 6'd10,
                    {8'h7F, 8'h5E, 8'h07, 8'h00, 8'h06, 8'h00, 8'h3F, 8'h06}};
        vecs[3] = '{12'h4C9, GAMING,       6'd63,
                    {8'h6F, 8'h39, 8'h66, 8'h00, 8'h3D, 8'h00, 8'h4F, 8'h7D}};
        vecs[4] = '{12'hB6E, CHOSE_BOARD,  6'd58,
                    {8'h79, 8'h7D, 8'h7C, 8'h00, 8'h39, 8'h00, 8'h7F, 8'h6D}};

        // Reset hold, then release and scan the table.
        rst = 1'b1;
        set_inputs(vecs[0].board, vecs[0].status, vecs[0].step);
        repeat (3) @(negedge clk_d);
        check("rst_an", an, 8'h00);
        check("rst_seg", seg, 8'h00);
        rst = 1'b0;
        run_after_reset(vecs[0].segs, "v0");
        for (int v = 1; v < 5; v++) begin
            set_inputs(vecs[v].board, vecs[v].status, vecs[v].step);
            run_frame(vecs[v].segs, $sformatf("v%0d", v));
        end

        // Mid-frame input changes wait for the next frame start.
        set_inputs(12'h000, GAMING, 6'd47);
        f = {8'h3F, 8'h3F, 8'h3F, 8'h00, 8'h3D, 8'h00, 8'h07, 8'h66};
        for (int d = 0; d < 8; d++) begin
            run_slot(d, f[d], "snap");
            if (d == 2) set_inputs(12'hFFF, GAMING, 6'd5);
        end
        run_frame({8'h71, 8'h71, 8'h71, 8'h00, 8'h3D, 8'h00, 8'h6D, 8'h00}, "snap2");

        // Blink: visible, visible, blank, blank, visible, visible, blank, blank.
        set_inputs(12'h111, WINNED, 6'd5);
        run_frame(win_frame(1'b0), "win1");
        run_frame(win_frame(1'b0), "win2");
        run_frame(win_frame(1'b1), "win3");
        run_frame(win_frame(1'b1), "win4");
        run_frame(win_frame(1'b0), "win5");
        run_frame(win_frame(1'b0), "win6");
        run_frame(win_frame(1'b1), "win7");
        f = win_frame(1'b1);
        for (int d = 0; d < 8; d++) begin
            run_slot(d, f[d], "win8");
            if (d == 3) game_status = GAMING;
        end

        // Leaving WINNED shows the board at once; re-entry restarts the count.
        run_frame({8'h06, 8'h06, 8'h06, 8'h00, 8'h3D, 8'h00, 8'h6D, 8'h00}, "leave");
        game_status = WINNED;
        run_frame(win_frame(1'b0), "rewin1");
        run_frame(win_frame(1'b0), "rewin2");
        run_frame(win_frame(1'b1), "rewin3");

        // Reset pulse while digit 4 is lit.
        set_inputs(12'h123, GAMING, 6'd21);
        f = {8'h4F, 8'h5B, 8'h06, 8'h00, 8'h3D, 8'h00, 8'h06, 8'h5B};
        for (int d = 0; d < 5; d++) run_slot(d, f[d], "pre_rst");
        rst = 1'b1;
        @(negedge clk_d);
        check("pulse_an", an, 8'h00);
        check("pulse_seg", seg, 8'h00);
        rst = 1'b0;
        set_inputs(12'h456, GAMING, 6'd21);
        run_after_reset({8'h7D, 8'h6D, 8'h66, 8'h00, 8'h3D, 8'h00, 8'h06, 8'h5B}, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
